// File: rtl/uart_alu_pkg.sv
// Shared definitions for the serial-controlled ALU: opcodes, FSM state
// encodings and the baud divisor computation.
package uart_alu_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {StWaitA, StWaitB, StWaitOp, StSend} ctrl_state_e;

  // Rounded clk_freq / (baud * os).
  function automatic int unsigned calc_divisor(int unsigned clk_freq, int unsigned baud,
                                               int unsigned os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; results wrap modulo 2^DATA_BITS.
module alu #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OP_BITS   = 6
) (
  input  logic [DATA_BITS-1:0] a_i,
  input  logic [DATA_BITS-1:0] b_i,
  input  logic [OP_BITS-1:0]   op_i,
  output logic [DATA_BITS-1:0] y_o
);
  import uart_alu_pkg::*;

  localparam int unsigned ShW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic           big_shift;
  logic [ShW-1:0] sh;

  // Opcode decode; oversized shifts saturate to zero or sign fill.
  always_comb begin
    big_shift = (b_i >= DATA_BITS'(DATA_BITS));
    sh        = b_i[ShW-1:0];
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_SRL:  y_o = big_shift ? '0 : (a_i >> sh);
      OP_SRA:  y_o = big_shift ? {DATA_BITS{a_i[DATA_BITS-1]}}
                               : $unsigned($signed(a_i) >>> sh);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/baud_gen.sv
// Free-running oversample tick generator.
module baud_gen #(
  parameter int unsigned DIVISOR = 326
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CntW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick on the terminal count, then wrap.
  always_comb begin
    tick_o = (cnt_q == CntW'(DIVISOR - 1));
    cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Interface FSM: collects A, B and opcode bytes, then launches the result.
module uart_alu_ctrl #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OP_BITS   = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_done_i,
  input  logic [DATA_BITS-1:0] rx_data_i,
  input  logic                 tx_done_i,
  input  logic [DATA_BITS-1:0] alu_y_i,
  output logic [DATA_BITS-1:0] a_o,
  output logic [DATA_BITS-1:0] b_o,
  output logic [OP_BITS-1:0]   op_o,
  output logic [DATA_BITS-1:0] result_o,
  output logic                 tx_start_o
);
  import uart_alu_pkg::*;

  ctrl_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [OP_BITS-1:0]   op_q;
  logic                 tx_start_q, tx_start_d;
  logic                 op_take;

  // The ALU sees the incoming opcode in the same cycle it is captured, so the
  // result can be registered without an extra cycle of latency.
  assign op_take    = (state_q == StWaitOp) && rx_done_i;
  assign op_o       = op_take ? rx_data_i[OP_BITS-1:0] : op_q;
  assign a_o        = a_q;
  assign b_o        = b_q;
  assign result_o   = result_q;
  assign tx_start_o = tx_start_q;

  // Byte sequencing; bytes arriving while sending are dropped.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    tx_start_d = 1'b0;
    case (state_q)
      StWaitA: begin
        if (rx_done_i) begin
          a_d     = rx_data_i;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (rx_done_i) begin
          b_d     = rx_data_i;
          state_d = StWaitOp;
        end
      end
      StWaitOp: begin
        if (rx_done_i) begin
          result_d   = alu_y_i;
          tx_start_d = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (tx_done_i) state_d = StWaitA;
      end
      default: state_d = StWaitA;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StWaitA;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_o;
      result_q   <= result_d;
      tx_start_q <= tx_start_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with input synchronizer and break handling.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 done_o
);
  import uart_alu_pkg::*;

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q;
  logic                 prev_q;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 done_q, done_d;
  logic                 rx_s;

  assign rx_s   = sync_q[1];
  assign data_o = shift_q;
  assign done_o = done_q;

  // Next-state: start detect, mid-bit sampling, stop check and break wait.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      RxIdle: begin
        if (prev_q && !rx_s) begin
          state_d = RxStart;
          tick_d  = '0;
        end
      end
      RxStart: begin
        if (tick_i) begin
          if (tick_q == TickW'(OVERSAMPLE / 2 - 1)) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? RxIdle : RxData;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      RxData: begin
        if (tick_i) begin
          if (tick_q == TickW'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BitW'(DATA_BITS - 1)) state_d = RxStop;
            else                               bit_d   = bit_q + BitW'(1);
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      RxStop: begin
        if (tick_i) begin
          if (tick_q == TickW'(OVERSAMPLE - 1)) begin
            tick_d = '0;
            if (rx_s) begin
              done_d  = 1'b1;
              state_d = RxIdle;
            end else begin
              state_d = RxBreak;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      RxBreak: begin
        if (rx_s) state_d = RxIdle;
      end
      default: state_d = RxIdle;
    endcase
  end

  // State, synchronizer and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RxIdle;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a registered, glitch-free serial output.
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 tx_o,
  output logic                 done_o
);
  import uart_alu_pkg::*;

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  tx_state_e            state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  assign tx_o   = tx_q;
  assign done_o = done_q;

  // Next-state and the line level for the upcoming state.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      TxIdle: begin
        if (start_i) begin
          shift_d = data_i;
          tick_d  = '0;
          bit_d   = '0;
          state_d = TxStart;
        end
      end
      TxStart: begin
        if (tick_i) begin
          if (tick_q == TickW'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            state_d = TxData;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      TxData: begin
        if (tick_i) begin
          if (tick_q == TickW'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            if (bit_q == BitW'(DATA_BITS - 1)) state_d = TxStop;
            else                               bit_d   = bit_q + BitW'(1);
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      TxStop: begin
        if (tick_i) begin
          if (tick_q == TickW'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = TxIdle;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      default: state_d = TxIdle;
    endcase

    case (state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset drives the line idle high at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TxIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/uart_alu_top.sv
// Chip-top serial ALU: UART in, three-byte command, one-byte result out.
module uart_alu_top #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = uart_alu_pkg::OVERSAMPLE,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OP_BITS    = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic tx
);

  localparam int unsigned DIVISOR = uart_alu_pkg::calc_divisor(CLK_FREQ, BAUD, OVERSAMPLE);

  logic                 tick;
  logic                 rx_done, tx_done, tx_start;
  logic [DATA_BITS-1:0] rx_data, alu_a, alu_b, alu_y, result;
  logic [OP_BITS-1:0]   alu_op;

  baud_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud (
    .clk_i (clock),
    .rst_i (reset),
    .tick_o(tick)
  );

  uart_rx #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rx (
    .clk_i (clock),
    .rst_i (reset),
    .tick_i(tick),
    .rx_i  (rx),
    .data_o(rx_data),
    .done_o(rx_done)
  );

  uart_alu_ctrl #(
    .DATA_BITS(DATA_BITS),
    .OP_BITS  (OP_BITS)
  ) u_ctrl (
    .clk_i     (clock),
    .rst_i     (reset),
    .rx_done_i (rx_done),
    .rx_data_i (rx_data),
    .tx_done_i (tx_done),
    .alu_y_i   (alu_y),
    .a_o       (alu_a),
    .b_o       (alu_b),
    .op_o      (alu_op),
    .result_o  (result),
    .tx_start_o(tx_start)
  );

  alu #(
    .DATA_BITS(DATA_BITS),
    .OP_BITS  (OP_BITS)
  ) u_alu (
    .a_i (alu_a),
    .b_i (alu_b),
    .op_i(alu_op),
    .y_o (alu_y)
  );

  uart_tx #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tx (
    .clk_i  (clock),
    .rst_i  (reset),
    .tick_i (tick),
    .start_i(tx_start),
    .data_i (result),
    .tx_o   (tx),
    .done_o (tx_done)
  );

endmodule

// File: tb/tb_uart_alu_top.sv
// Self-checking bench for uart_alu_top with a scaled-down baud rate.
module tb_uart_alu_top;

  // 4800 Hz / (100 baud * 16) = divisor 3, so one serial bit is 48 clocks.
  localparam int unsigned ClkFreq = 4800;
  localparam int unsigned Baud    = 100;
  localparam int unsigned Os      = 16;
  localparam int unsigned BitClks = ClkFreq / Baud;
  localparam int unsigned Timeout = 5 * 10 * BitClks;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic tx;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t dir_vec[11] = '{
    '{8'h05, 8'h07, 8'h22, 8'hFE},
    '{8'h80, 8'h02, 8'h03, 8'hE0},
    '{8'h80, 8'h02, 8'h02, 8'h20},
    '{8'hF0, 8'h0F, 8'h27, 8'h00},
    '{8'h11, 8'h22, 8'h3F, 8'h00},
    '{8'hFF, 8'h01, 8'h20, 8'h00},
    '{8'h80, 8'h09, 8'h03, 8'hFF},
    '{8'h80, 8'h08, 8'h02, 8'h00},
    '{8'h3C, 8'h0F, 8'hE5, 8'h3F},
    '{8'h3C, 8'h0F, 8'h26, 8'h33},
    '{8'h7F, 8'h03, 8'h03, 8'h0F}
  };

  logic [5:0] op_pool[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03,
                              6'h00, 6'h3F};

  uart_alu_top #(
    .CLK_FREQ  (ClkFreq),
    .BAUD      (Baud),
    .OVERSAMPLE(Os),
    .DATA_BITS (8),
    .OP_BITS   (6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx   (rx),
    .tx   (tx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU from the arithmetic definition of each operation.
  function automatic int alu_ref(input int a, input int b, input int op);
    int sa, r, p;
    case (op)
      'h20: return (a + b) % 256;
      'h22: return (a - b + 256) % 256;
      'h24: return a & b;
      'h25: return a | b;
      'h26: return a ^ b;
      'h27: return 255 - (a | b);
      'h02: return (b >= 8) ? 0 : a / (1 << b);
      'h03: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) return (sa < 0) ? 255 : 0;
        p = 1 << b;
        r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        return (r + 256) % 256;
      end
      default: return 0;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] val);
    rx = 1'b0;
    repeat (BitClks) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = val[i];
      repeat (BitClks) @(negedge clock);
    end
    rx = 1'b1;
    repeat (BitClks) @(negedge clock);
  endtask

  // Captures {stop, data[7:0], start} sampled at bit centres.
  task automatic recv_frame(output logic [9:0] frame, output logic ok);
    int n = 0;
    frame = '0;
    while (tx !== 1'b0 && n < Timeout) begin
      @(negedge clock);
      n++;
    end
    ok = (n < Timeout);
    repeat (BitClks / 2) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      frame[i] = tx;
      if (i < 9) repeat (BitClks) @(negedge clock);
    end
  endtask

  task automatic watch_high(input int cycles, output logic saw_low);
    saw_low = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
  endtask

  task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] op, input logic [7:0] exp);
    logic [9:0] frame;
    logic       ok;
    fork
      begin
        send_byte(a);
        send_byte(b);
        send_byte(op);
      end
      recv_frame(frame, ok);
    join
    check({tag, "_seen"}, 32'(ok), 32'd1);
    check(tag, 32'(frame), 32'({1'b1, exp, 1'b0}));
    repeat (BitClks) @(negedge clock);
  endtask

  initial begin
    logic       saw_low;
    logic [7:0] ra, rb, rop;
    int         n;

    repeat (5) @(negedge clock);
    check("reset_tx", 32'(tx), 32'd1);
    reset = 1'b0;

    watch_high(1000, saw_low);
    check("idle_tx_high", 32'(saw_low), 32'd0);

    rx = 1'b0;
    watch_high(40 * BitClks, saw_low);
    check("break_tx_high", 32'(saw_low), 32'd0);
    rx = 1'b1;
    repeat (4 * BitClks) @(negedge clock);
    txn("break_recover", 8'h05, 8'h03, 8'h20, 8'h08);

    foreach (dir_vec[i]) begin
      txn($sformatf("dir%0d", i), dir_vec[i].a, dir_vec[i].b, dir_vec[i].op, dir_vec[i].exp);
    end

    // Reset partway through the B byte; the partial frame must be lost.
    send_byte(8'h55);
    rx = 1'b0;
    repeat (BitClks) @(negedge clock);
    rx = 1'b1;
    repeat (3 * BitClks) @(negedge clock);
    reset = 1'b1;
    rx    = 1'b1;
    #1;
    check("rst_midb_tx", 32'(tx), 32'd1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (2 * BitClks) @(negedge clock);
    txn("after_rst_and", 8'h0A, 8'h0B, 8'h24, 8'h0A);

    // Reset while a result is on the line; tx must go high at once.
    send_byte(8'h05);
    send_byte(8'h07);
    send_byte(8'h22);
    n = 0;
    while (tx !== 1'b0 && n < Timeout) begin
      @(negedge clock);
      n++;
    end
    check("rst_tx_busy", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_tx_forced", 32'(tx), 32'd1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    watch_high(12 * BitClks, saw_low);
    check("rst_tx_quiet", 32'(saw_low), 32'd0);
    txn("after_rst_tx", 8'h12, 8'h34, 8'h20, 8'h46);

    for (int i = 0; i < 8; i++) begin
      n   = $urandom_range(0, 9);
      ra  = 8'($urandom_range(0, 255));
      rop = {2'($urandom_range(0, 3)), op_pool[n]};
      if (n == 9) rop = 8'($urandom_range(0, 255));
      if (rop[5:0] == 6'h02 || rop[5:0] == 6'h03) rb = 8'($urandom_range(0, 11));
      else                                        rb = 8'($urandom_range(0, 255));
      txn($sformatf("rnd%0d_%02h_%02h_%02h", i, ra, rb, rop), ra, rb, rop,
          8'(alu_ref(int'(ra), int'(rb), int'(rop[5:0]))));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_alu_top.md
Name: uart_alu_top

Overview:
- Top-level serial-controlled ALU.
- A UART receiver collects three bytes from the host: operand A, operand B and the opcode.
- An interface FSM passes the operands and opcode to a combinational ALU, then returns the 8-bit result to the host through a UART transmitter.
- Sits at chip top; the only external signals are clock, reset, rx and tx.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- OVERSAMPLE, 16, baud ticks per serial bit.
- DATA_BITS, 8, UART data bits per frame; also the ALU operand/result width.
- OP_BITS, 6, opcode width, taken from the low bits of the opcode byte.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial input, 8N1, LSB first, idle high; double-flopped before use.
- tx  output  1  serial output, 8N1, LSB first, idle high.

Behaviour:
- Reset: tx=1, FSM in WAIT_A, registers A/B/OP/result=0, baud counter=0, no tx_start, rx FSM IDLE.
- Baud generator:
  - DIVISOR = round(CLK_FREQ/(BAUD*OVERSAMPLE)), which is 326 at the defaults.
  - Free-running counter; emits a 1-cycle tick when the counter reaches DIVISOR-1, then wraps to 0.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge on the synchronized rx moves to START with the tick count cleared.
  - START: at tick 7, if rx is still 0 go to DATA; otherwise it was a glitch, return to IDLE.
  - DATA: sample every 16 ticks, shifting LSB first, for DATA_BITS bits.
  - STOP: after 16 ticks, if rx=1 pulse rx_done for 1 cycle with rx_data valid.
  - Framing error (stop bit 0): no rx_done, byte discarded. The receiver stays in a BREAK wait until rx returns to 1 before re-arming. A continuously low line therefore produces no bytes.
- TX FSM: IDLE -> START -> DATA -> STOP, 16 ticks per bit.
  - tx_start is accepted only in IDLE.
  - Data is latched at start.
  - tx_done pulses 1 cycle at the end of the stop bit.
- Interface FSM: WAIT_A -> WAIT_B -> WAIT_OP -> SEND -> WAIT_A.
  - Each rx_done stores rx_data into A, B, OP[OP_BITS-1:0] respectively; the upper opcode-byte bits are ignored.
  - On the OP byte, the ALU result is registered. The FSM enters SEND and pulses tx_start on the next cycle.
  - In SEND it waits for tx_done, then returns to WAIT_A.
  - rx_done arriving during SEND is dropped.
  - Latency: tx start bit begins within 2 clocks after the rx_done of the OP byte.
- ALU (combinational, DATA_BITS wide, carries discarded, wrap-around modulo 2^8):
  - 100000 ADD
  - 100010 SUB (A-B)
  - 100100 AND
  - 100101 OR
  - 100110 XOR
  - 100111 NOR
  - 000011 SRA (A >>> B, arithmetic)
  - 000010 SRL (A >> B)
  - Shift amounts >= 8 give 0x00 for SRL, and all sign bits for SRA.
  - Any other opcode gives 0x00.
- Reset mid-frame: all FSMs return to idle, tx forced high immediately, partially received bytes lost.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL;
  - state encodings for the RX, TX and interface FSMs;
  - OVERSAMPLE and the DIVISOR computation function.
- Sub-modules: baud_gen, uart_rx, uart_tx, alu and the interface FSM, instantiated in uart_alu_top.
- The single most natural split is alu (pure combinational).

Test Plan:
- Hold rx=1 after reset -> tx stays 1 indefinitely, no transmission.
- Drive rx=0 continuously after reset (break) -> framing error, no byte accepted, tx stays 1, FSM remains WAIT_A. Release rx=1, then send 0x05, 0x03, 0x20 -> tx returns 0x08.
- Send 0x05, 0x07, 0x22 (SUB) -> tx frame 0xFE (start 0, bits LSB first, stop 1, 16*326 clocks per bit).
- Send 0x80, 0x02, 0x03 (SRA) -> 0xE0. Send 0x80, 0x02, 0x02 (SRL) -> 0x20. Send 0xF0, 0x0F, 0x27 (NOR) -> 0x00.
- Send 0x11, 0x22, 0x3F (undefined) -> 0x00. Send 0xFF, 0x01, 0x20 -> 0x00 (wrap-around).
- Assert reset midway through the B byte -> tx=1 immediately. Then send 0x0A, 0x0B, 0x24 (AND) -> 0x0A.
